// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared command encodings, slave FSM states and width helper for the crossbar
package crossbar_pkg;
    localparam logic CMD_READ = 1'b0;
    localparam logic CMD_WRITE = 1'b1;
    typedef enum logic {IDLE, BUSY} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/crossbar_rr_arbiter.sv
// rr_arbiter: picks the first requester after the last served index, wrapping modulo N
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N = 2,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);
    always_comb begin
        grant = '0;
        valid = 1'b0;
        // scan from the far end so the nearest requester after last overwrites the rest
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                grant = IW'((int'(last) + k) % N);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/crossbar_nxm.sv
// crossbar_nxm: N-master x M-slave req/ack crossbar with a round-robin arbiter per slave
module crossbar_nxm
    import crossbar_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SSW = clog2(N_SLAVES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    master_req,
    input  logic [N_MASTERS-1:0]    master_cmd,
    input  logic [N_MASTERS*AW-1:0] master_addr,
    input  logic [N_MASTERS*DW-1:0] master_wdata,
    output logic [N_MASTERS*DW-1:0] master_rdata,
    output logic [N_MASTERS-1:0]    master_ack,
    output logic [N_SLAVES-1:0]     slave_req,
    output logic [N_SLAVES-1:0]     slave_cmd,
    output logic [N_SLAVES*AW-1:0]  slave_addr,
    output logic [N_SLAVES*DW-1:0]  slave_wdata,
    input  logic [N_SLAVES*DW-1:0]  slave_rdata,
    input  logic [N_SLAVES-1:0]     slave_ack
);
    localparam int MW = clog2(N_MASTERS);
    state_t               state_q [N_SLAVES];
    state_t               state_d [N_SLAVES];
    logic [MW-1:0]        grant_q [N_SLAVES];
    logic [MW-1:0]        grant_d [N_SLAVES];
    logic [MW-1:0]        last_q [N_SLAVES];
    logic [MW-1:0]        last_d [N_SLAVES];
    logic [MW-1:0]        arb_grant [N_SLAVES];
    logic [N_MASTERS-1:0] tgt [N_SLAVES];
    logic [N_SLAVES-1:0]  arb_valid;
    logic [N_SLAVES-1:0]  busy;

    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                tgt[j][i] = master_req[i] && master_addr[i*AW + AW - 1 -: SSW] == SSW'(j);
            end
        end
    end

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_arb
        rr_arbiter #(.N(N_MASTERS), .IW(MW)) u_arb (
            .req   (tgt[g]),
            .last  (last_q[g]),
            .grant (arb_grant[g]),
            .valid (arb_valid[g])
        );
    end

    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            state_d[j] = state_q[j];
            grant_d[j] = grant_q[j];
            last_d[j] = last_q[j];
            if (state_q[j] == IDLE && arb_valid[j]) begin
                state_d[j] = BUSY;
                grant_d[j] = arb_grant[j];
            end else if (state_q[j] == BUSY && slave_ack[j]) begin
                state_d[j] = IDLE;
                last_d[j] = grant_q[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N_SLAVES; j++) begin
            if (rst) begin
                state_q[j] <= IDLE;
                grant_q[j] <= '0;
                last_q[j] <= MW'(N_MASTERS - 1);
            end else begin
                state_q[j] <= state_d[j];
                grant_q[j] <= grant_d[j];
                last_q[j] <= last_d[j];
            end
        end
    end

    // outputs are forced quiet while rst is high so a stray slave_ack cannot leak through
    always_comb begin
        for (int j = 0; j < N_SLAVES; j++) begin
            busy[j] = !rst && state_q[j] == BUSY;
            slave_req[j] = busy[j];
            slave_cmd[j] = busy[j] ? master_cmd[grant_q[j]] : CMD_READ;
            slave_addr[j*AW +: AW] = busy[j] ? master_addr[grant_q[j]*AW +: AW] : '0;
            slave_wdata[j*DW +: DW] = busy[j] ? master_wdata[grant_q[j]*DW +: DW] : '0;
        end
    end

    always_comb begin
        master_ack = '0;
        master_rdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                master_ack[i] = master_ack[i] | (busy[j] && grant_q[j] == MW'(i) && slave_ack[j]);
                master_rdata[i*DW +: DW] = master_rdata[i*DW +: DW]
                    | ({DW{busy[j] && grant_q[j] == MW'(i) && slave_ack[j]}} & slave_rdata[j*DW +: DW]);
            end
        end
    end
endmodule
